kernel_stream_feeder: RTL and testbench
=======================================

// Module: kernel_stream_feeder
// PURPOSE
//  Transmit-side counterpart of the kernel_top stream input. Accepts a burst of
//  words from the host/memory side, buffers them in a small FWFT FIFO, and drives
//  a kernel's ivalid/in1 ports under the kernel's iready back-pressure.
//  Runs one job of NWORDS words per start pulse and flags done when the kernel
//  has consumed every word.
// PARAMETERS
//  STREAMW    34  data width of host and kernel streams (matches kernel stream width)
//  CNTW       16  word-count width; max job length 2^CNTW-1
//  FIFO_DEPTH 4   buffer entries; power of 2, >=2
// PORTS
//  clk         in   1        clock
//  rst         in   1        synchronous reset, ACTIVE-LOW (0 = reset)
//  start       in   1        pulse; begins job when in IDLE, ignored otherwise
//  nwords      in   CNTW     job length, sampled on accepted start
//  host_valid  in   1        host word valid
//  host_data   in   STREAMW  host word
//  host_ready  out  1        feeder accepts host word this cycle
//  ovalid      out  1        to kernel ivalid_in1
//  out1        out  STREAMW  to kernel in1
//  kready      in   1        from kernel iready
//  busy        out  1        high in RUN
//  done        out  1        one-cycle pulse at job completion
//  sent_cnt    out  CNTW     words consumed by kernel in current/last job
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, FIFO emptied, counters=0;
//   host_ready=0, ovalid=0, out1=0, busy=0, done=0, sent_cnt=0. Reset mid-job
//   discards buffered words; no partial done.
//  FSM: IDLE -start-> RUN (latch nwords, clear acc_cnt, sent_cnt); if nwords==0
//   IDLE -start-> DONE directly. RUN -(sent_cnt reaches nwords)-> DONE.
//   DONE -> IDLE unconditionally next cycle; done=1 only in DONE.
//  Host push: host_ready = (state==RUN) & !full & (acc_cnt < nwords_r);
//   push when host_valid & host_ready; acc_cnt++ per push. host_ready uses
//   registered full, so no push into a full FIFO even with same-cycle pop.
//  Kernel pop: ovalid = !empty; out1 = head word (FWFT). Pop on ovalid & kready;
//   sent_cnt++ per pop. Transition to DONE when the pop makes sent_cnt==nwords_r.
//  Latency: word pushed at cycle t visible on out1/ovalid at t+1 (empty FIFO).
//  Stall: while ovalid & !kready, out1 and ovalid held stable (no drop, no change).
//  Simultaneous push+pop (not full, not empty): occupancy unchanged, order kept.
//  Pointers log2(FIFO_DEPTH)+1 bits, wrap naturally; full = MSB differ, rest equal.
//  Occupancy never exceeds FIFO_DEPTH; words beyond nwords never accepted.
//  start during RUN/DONE ignored; new start accepted only in IDLE (cycle after done).
//  sent_cnt holds final value in IDLE until next accepted start.
// TESTING
//  T1 reset: rst=0 2 cycles with host_valid=1,kready=1 -> all outputs 0, state IDLE.
//  T2 nwords=8, host_valid=1, kready=1 always -> out1 = 8 words in order, first
//   ovalid 1 cycle after first push, done pulse once, sent_cnt=8, host_ready=0 after 8.
//  T3 nwords=10, kready=0 for 20 cycles -> exactly 4 words accepted, host_ready=0,
//   out1 stable on word0; release kready -> remaining 10 delivered in order, done.
//  T4 nwords=0 start -> done pulse next cycle, no host_ready, no ovalid.
//  T5 random host_valid/kready (50%), nwords=100 -> scoreboard match 100 words,
//   no loss/dup, start pulses mid-job ignored.
//  T6 rst=0 after 3 of 8 words sent -> FIFO flushed, ovalid=0, no done; new
//   job nwords=2 completes normally with sent_cnt=2.

Source files
------------

// File: rtl/kernel_stream_feeder.sv
// Host-to-kernel stream feeder: buffers a job of host words in a small
// first-word-fall-through FIFO and drives them out under kernel back-pressure.
module kernel_stream_feeder #(
  parameter int STREAMW    = 34,
  parameter int CNTW       = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNTW-1:0]    nwords,
  input  logic               host_valid,
  input  logic [STREAMW-1:0] host_data,
  output logic               host_ready,
  output logic               ovalid,
  output logic [STREAMW-1:0] out1,
  input  logic               kready,
  output logic               busy,
  output logic               done,
  output logic [CNTW-1:0]    sent_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CNTW-1:0] nwords_q, nwords_d;
  logic [CNTW-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNTW-1:0] sent_cnt_q, sent_cnt_d;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  logic [STREAMW-1:0] mem_q [FIFO_DEPTH];
  logic [STREAMW-1:0] mem_d [FIFO_DEPTH];

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic last_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Registered full only: a same-cycle pop never frees room for a push.
  assign host_ready = (state_q == S_RUN) && !full &&
                      (acc_cnt_q < nwords_q);

  assign push = host_valid && host_ready;
  assign ovalid = !empty;
  assign pop = ovalid && kready;

  assign out1 = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sent_cnt = sent_cnt_q;

  assign last_pop = pop && ((sent_cnt_q + CNTW'(1)) == nwords_q);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = host_data;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    nwords_d   = nwords_q;
    acc_cnt_d  = acc_cnt_q;
    sent_cnt_d = sent_cnt_q;
    if (push) begin
      acc_cnt_d = acc_cnt_q + CNTW'(1);
    end
    if (pop) begin
      sent_cnt_d = sent_cnt_q + CNTW'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          nwords_d   = nwords;
          acc_cnt_d  = '0;
          sent_cnt_d = '0;
          state_d    = (nwords == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_pop) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      nwords_q   <= '0;
      acc_cnt_q  <= '0;
      sent_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      nwords_q   <= nwords_d;
      acc_cnt_q  <= acc_cnt_d;
      sent_cnt_q <= sent_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_kernel_stream_feeder.sv
// Bench for kernel_stream_feeder: queue-based job model, random host data
// and handshakes, directed reset/stall/zero-length/abort scenarios.
module tb_kernel_stream_feeder;

  localparam int W  = 34;
  localparam int CW = 16;
  localparam int DEPTH = 4;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] nwords;
  logic          host_valid;
  logic [W-1:0]  host_data;
  logic          host_ready;
  logic          ovalid;
  logic [W-1:0]  out1;
  logic          kready;
  logic          busy;
  logic          done;
  logic [CW-1:0] sent_cnt;

  always #5 clk = ~clk;

  kernel_stream_feeder #(
    .STREAMW(W),
    .CNTW(CW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .nwords(nwords),
    .host_valid(host_valid),
    .host_data(host_data),
    .host_ready(host_ready),
    .ovalid(ovalid),
    .out1(out1),
    .kready(kready),
    .busy(busy),
    .done(done),
    .sent_cnt(sent_cnt)
  );

  int checks   = 0;
  int failures = 0;

  int           m_state = M_IDLE;
  logic [W-1:0] m_q[$];
  int           m_acc  = 0;
  int           m_sent = 0;
  int           m_nw   = 0;

  int           done_seen  = 0;
  int           pushes_seen = 0;
  logic [W-1:0] acc_log[$];
  logic [W-1:0] dlv_log[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rs, input logic st,
                     input logic [CW-1:0] nw, input logic hv,
                     input logic kr);
    logic [W-1:0] hd;
    bit hr, ov, psh, pp;
    logic [W-1:0] e_out;
    hd = {2'($urandom), 32'($urandom)};
    rst = rs;
    start = st;
    nwords = nw;
    host_valid = hv;
    host_data = hd;
    kready = kr;
    if (rs && hv && host_ready === 1'b1) pushes_seen++;
    hr = (m_state == M_RUN) && (m_q.size() < DEPTH) && (m_acc < m_nw);
    ov = (m_q.size() != 0);
    @(posedge clk);
    if (!rs) begin
      m_state = M_IDLE;
      m_q.delete();
      m_acc = 0;
      m_sent = 0;
      m_nw = 0;
    end else begin
      psh = hv && hr;
      pp  = ov && kr;
      case (m_state)
        M_IDLE: if (st) begin
          m_nw = int'(nw);
          m_acc = 0;
          m_sent = 0;
          m_state = (nw == 0) ? M_DONE : M_RUN;
        end
        M_RUN: if (pp) begin
          m_sent++;
          if (m_sent == m_nw) m_state = M_DONE;
        end
        default: m_state = M_IDLE;
      endcase
      if (pp) dlv_log.push_back(m_q.pop_front());
      if (psh) begin
        m_q.push_back(hd);
        acc_log.push_back(hd);
        m_acc++;
      end
    end
    #1;
    hr = (m_state == M_RUN) && (m_q.size() < DEPTH) && (m_acc < m_nw);
    e_out = (m_q.size() != 0) ? m_q[0] : '0;
    chk("host_ready", host_ready, hr);
    chk("ovalid", ovalid, m_q.size() != 0);
    chk("out1", out1, e_out);
    chk("busy", busy, m_state == M_RUN);
    chk("done", done, m_state == M_DONE);
    chk("sent_cnt", sent_cnt, m_sent);
    if (done === 1'b1) done_seen++;
  endtask

  task automatic run_job(input int nw, input int hvp, input int krp,
                         input bit mid_start, input int budget);
    int n;
    done_seen = 0;
    acc_log.delete();
    dlv_log.delete();
    cyc(1'b1, 1'b1, CW'(nw), $urandom_range(99) < hvp,
        $urandom_range(99) < krp);
    n = 0;
    while (m_state != M_IDLE && n < budget) begin
      cyc(1'b1, mid_start && ($urandom_range(9) == 0), CW'($urandom),
          $urandom_range(99) < hvp, $urandom_range(99) < krp);
      n++;
    end
    chk("job_end_busy", busy, 1'b0);
    chk("done_pulses", done_seen, 1);
    chk("sent_final", sent_cnt, nw);
    chk("delivered_count", dlv_log.size(), nw);
    chk("accepted_count", acc_log.size(), nw);
    for (int i = 0; i < dlv_log.size() && i < acc_log.size(); i++) begin
      if (dlv_log[i] !== acc_log[i]) begin
        chk("order", dlv_log[i], acc_log[i]);
      end
    end
  endtask

  initial begin
    logic [W-1:0] w0;
    int n;

    // T1: reset with active handshakes
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("t1_out1", out1, '0);
    chk("t1_sent", sent_cnt, '0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);

    // T2: streaming job
    run_job(8, 100, 100, 1'b0, 40);
    chk("t2_host_ready_after", host_ready, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
    chk("t2_sent_hold", sent_cnt, 8);

    // T3: kernel stalled, FIFO fills
    acc_log.delete();
    dlv_log.delete();
    done_seen = 0;
    cyc(1'b1, 1'b1, CW'(10), 1'b1, 1'b0);
    pushes_seen = 0;
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("t3_pushes", pushes_seen, 4);
    chk("t3_host_ready", host_ready, 1'b0);
    chk("t3_ovalid", ovalid, 1'b1);
    w0 = acc_log.size() != 0 ? acc_log[0] : '0;
    chk("t3_out1_word0", out1, w0);
    n = 0;
    while (m_state != M_IDLE && n < 60) begin
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
      n++;
    end
    chk("t3_done_pulses", done_seen, 1);
    chk("t3_sent", sent_cnt, 10);
    chk("t3_delivered", dlv_log.size(), 10);
    for (int i = 0; i < dlv_log.size() && i < acc_log.size(); i++) begin
      if (dlv_log[i] !== acc_log[i]) chk("t3_order", dlv_log[i], acc_log[i]);
    end

    // T4: zero-length job
    run_job(0, 100, 100, 1'b0, 5);

    // T5: random handshakes, ignored mid-job starts
    run_job(100, 50, 50, 1'b1, 2000);

    // T6: abort mid-job by reset
    done_seen = 0;
    cyc(1'b1, 1'b1, CW'(8), 1'b1, 1'b1);
    n = 0;
    while (m_sent < 3 && n < 20) begin
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
      n++;
    end
    chk("t6_sent_before", sent_cnt, 3);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("t6_ovalid", ovalid, 1'b0);
    chk("t6_no_done", done_seen, 0);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
    chk("t6_idle_ovalid", ovalid, 1'b0);
    run_job(2, 100, 100, 1'b0, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
